// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes only from registered state and freeze/flush, so it never depends
// combinationally on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   freeze     hazard stall: hold all contents, no accept, no issue
//   flush      synchronous squash of all held entries; has priority over freeze
//   in_valid   upstream payload valid
//   in_ready   stage can accept this cycle
//   in_data    upstream payload
//   out_valid  payload available downstream
//   out_ready  downstream accepts
//   out_data   payload to the next stage (FLUSH_VAL when the stage is empty)
//   stall_cnt  saturating count of cycles a held entry could not leave
module pipe_stage_skid_reg #(
    parameter int unsigned          DATA_W    = 64,
    parameter logic [DATA_W-1:0]    FLUSH_VAL = '0,
    parameter int unsigned          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy is {skid_v, main_v}: 00 empty, 01 one entry, 11 full. 10 is unreachable.
    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic accept;
    logic fire;

    assign in_ready  = !skid_v_q && !freeze && !flush;
    assign out_valid = main_v_q && !freeze;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;

    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_data_d = FLUSH_VAL;
        end else if (!freeze) begin
            case ({skid_v_q, main_v_q})
                2'b00: begin
                    if (accept) begin
                        main_v_d    = 1'b1;
                        main_data_d = in_data;
                    end
                end
                2'b01: begin
                    if (accept && fire) begin
                        main_data_d = in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the newcomer behind the head entry.
                        skid_v_d    = 1'b1;
                        skid_data_d = in_data;
                    end else if (fire) begin
                        main_v_d    = 1'b0;
                        main_data_d = FLUSH_VAL;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only the drain path is possible.
                    if (fire) begin
                        main_data_d = skid_data_q;
                        skid_v_d    = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_v_q && (freeze || !out_ready) && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_data_q <= FLUSH_VAL;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed and random stimulus, with a queue-based
// reference model (the stage is a 2-deep FIFO whose head is visible on out_data).
module tb_pipe_stage_skid_reg;

    localparam int unsigned DW = 32;
    localparam logic [DW-1:0] FV = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [15:0]   stall_cnt;

    // Second instance with a 2-bit counter for saturation checks.
    logic       s_rst, s_in_valid, s_in_ready, s_out_valid;
    logic [7:0] s_in_data, s_out_data;
    logic [1:0] s_stall_cnt;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] q[$];
    logic [15:0]   exp_stall;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.DATA_W(DW), .FLUSH_VAL(FV), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_skid_reg #(.DATA_W(8), .FLUSH_VAL(8'h00), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(s_rst), .freeze(1'b0), .flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(1'b0), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: the queue size is the stage occupancy before the coming edge.
    initial begin
        forever begin
            int occ;
            logic efire;
            @(negedge clk);
            if (rst) begin
                q.delete();
                exp_stall = '0;
                continue;
            end
            occ = q.size();
            chk("in_ready", {31'b0, in_ready}, {31'b0, (occ < 2) && !freeze && !flush});
            chk("out_valid", {31'b0, out_valid}, {31'b0, (occ > 0) && !freeze});
            chk("stall_cnt", {16'b0, stall_cnt}, {16'b0, exp_stall});
            if (occ > 0) chk("out_data", out_data, q[0]);
            else         chk("out_data_empty", out_data, FV);
            efire = (occ > 0) && !freeze && out_ready;
            if (efire) void'(q.pop_front());
            if ((occ > 0) && (freeze || !out_ready) && !flush && (exp_stall != 16'hFFFF))
                exp_stall = exp_stall + 16'd1;
        end
    end

    // Called at posedge+1; returns at the next posedge+1. Flush squashes the model queue
    // after the monitor has consumed anything delivered in that cycle.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                        input logic frz, input logic fl, output logic acc);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        freeze    = frz;
        flush     = fl;
        @(negedge clk);
        #1;
        acc = 1'b0;
        if (!rst) begin
            if (flush) q.delete();
            else if (in_valid && in_ready) begin
                q.push_back(in_data);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        logic [15:0] s0;
        int tries;
        rst = 1'b1; freeze = 0; flush = 0; in_valid = 0; out_ready = 0; in_data = '0;
        s_rst = 1'b1; s_in_valid = 0; s_in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, FV);
        chk("rst_stall", {16'b0, stall_cnt}, 32'd0);

        // Single entry, one-cycle latency, then back to bubble.
        step(1, 32'hA, 1, 0, 0, acc);
        step(0, 0, 1, 0, 0, acc);
        step(0, 0, 1, 0, 0, acc);
        // Back-to-back stream.
        for (int i = 1; i <= 4; i++) step(1, i, 1, 0, 0, acc);
        step(0, 0, 1, 0, 0, acc);
        // Fill to FULL with downstream stalled, 7 waits upstream.
        s0 = stall_cnt;
        step(1, 5, 0, 0, 0, acc);
        step(1, 6, 0, 0, 0, acc);
        step(1, 7, 0, 0, 0, acc);
        chk("seven_held", {31'b0, acc}, 32'd0);
        step(1, 7, 0, 0, 0, acc);
        chk("stall_5_6", {16'b0, stall_cnt}, {16'b0, s0 + 16'd3});
        tries = 0;
        do begin
            step(1, 7, 1, 0, 0, acc);
            tries++;
        end while (!acc && tries < 10);
        chk("seven_accepted", {31'b0, acc}, 32'd1);
        repeat (3) step(0, 0, 1, 0, 0, acc);
        // Flush from FULL, then flush together with freeze.
        step(1, 8, 0, 0, 0, acc);
        step(1, 9, 0, 0, 0, acc);
        step(1, 32'h55, 0, 0, 1, acc);
        chk("flush_no_accept", {31'b0, acc}, 32'd0);
        step(1, 32'h10, 0, 0, 0, acc);
        step(0, 0, 0, 1, 1, acc);
        step(0, 0, 1, 0, 0, acc);
        // Freeze for three cycles holding 0xB.
        step(1, 32'hB, 0, 0, 0, acc);
        s0 = stall_cnt;
        repeat (3) begin
            step(1, 32'hC, 1, 1, 0, acc);
            chk("freeze_no_accept", {31'b0, acc}, 32'd0);
        end
        chk("freeze_stall", {16'b0, stall_cnt}, {16'b0, s0 + 16'd3});
        chk("freeze_hold", out_data, 32'hB);
        step(0, 0, 1, 0, 0, acc);
        step(0, 0, 1, 0, 0, acc);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0), acc);
        end
        repeat (4) step(0, 0, 1, 0, 0, acc);

        // Asynchronous reset in the middle of a cycle while FULL.
        step(1, 32'h77, 0, 0, 0, acc);
        step(1, 32'h78, 0, 0, 0, acc);
        in_valid = 0;
        chk("pre_rst_full", {31'b0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_in_ready", {31'b0, in_ready}, 32'd1);
        chk("async_out_data", out_data, FV);
        chk("async_stall", {16'b0, stall_cnt}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        step(0, 0, 1, 0, 0, acc);

        // Saturating 2-bit counter: one entry stalled for six edges.
        #1 s_rst = 1'b0;
        @(posedge clk);
        #1 s_in_valid = 1'b1; s_in_data = 8'h5A;
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        chk("sat_valid", {31'b0, s_out_valid}, 32'd1);
        chk("sat_zero", {30'b0, s_stall_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 chk("sat_two", {30'b0, s_stall_cnt}, 32'd2);
        repeat (4) @(posedge clk);
        #1 chk("sat_three", {30'b0, s_stall_cnt}, 32'd3);
        chk("sat_data", {24'b0, s_out_data}, 32'h5A);
        #2 s_rst = 1'b1;
        #1 chk("sat_rst", {30'b0, s_stall_cnt}, 32'd0);
        chk("sat_rst_valid", {31'b0, s_out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
